// File: rtl/sim_mem_pkg.sv
// Shared types and constants for the N-port simulation RAM model.
package sim_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int COLL_CNT_W = 16;

  // Word address width; a single-word memory still gets a 1-bit address.
  function automatic int addr_width(input int length);
    return (length > 2) ? $clog2(length) : 1;
  endfunction

endpackage

// File: rtl/sim_mem_nport_if.sv
// Bundled request/response signals of the N-port RAM model.
interface sim_mem_nport_if
  import sim_mem_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LENGTH = 32,
  parameter int PORTS  = 2
);
  localparam int AW = addr_width(LENGTH);

  logic                             ready_o;
  logic [PORTS-1:0]                 en_i;
  logic [PORTS-1:0][AW-1:0]         addr_i;
  logic [PORTS-1:0][WIDTH-1:0]      dataIn_i;
  logic [PORTS-1:0][WIDTH-1:0]      wrMask_i;
  logic [PORTS-1:0][WIDTH-1:0]      dataOut_o;
  logic [PORTS-1:0]                 valid_o;
  logic                             collision_o;
  logic [COLL_CNT_W-1:0]            collisionCnt_o;

  modport master (
    output en_i, addr_i, dataIn_i, wrMask_i,
    input  ready_o, dataOut_o, valid_o, collision_o, collisionCnt_o
  );

  modport slave (
    input  en_i, addr_i, dataIn_i, wrMask_i,
    output ready_o, dataOut_o, valid_o, collision_o, collisionCnt_o
  );

endinterface

// File: rtl/sim_mem_delay_line.sv
// Read-return shift register: carries data and valid for DELAY cycles.
module sim_mem_delay_line #(
  parameter int WIDTH = 16,
  parameter int DELAY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_p [DELAY];
  logic [DELAY-1:0] vld_p;

  // Data only advances with its valid, so the output holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
      for (int k = 0; k < DELAY; k++) data_p[k] <= '0;
    end else begin
      vld_p[0] <= vld_i;
      if (vld_i) data_p[0] <= data_i;
      for (int k = 1; k < DELAY; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) data_p[k] <= data_p[k-1];
      end
    end
  end

  assign vld_o  = vld_p[DELAY-1];
  assign data_o = data_p[DELAY-1];

endmodule

// File: rtl/sim_mem_nport.sv
// N-port behavioural RAM with bit masks, read latency, collision tracking
// and a self-clearing start-up sequence.
module sim_mem_nport
  import sim_mem_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter int              LENGTH      = 32,
  parameter int              PORTS       = 2,
  parameter int              DELAY       = 1,
  parameter int              WRITE_FIRST = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sim_mem_nport_if.slave  bus
);

  localparam int AW = addr_width(LENGTH);

  logic [WIDTH-1:0]            mem [LENGTH];
  mem_state_e                  state_q, state_d;
  logic [AW-1:0]               clr_ptr_q, clr_ptr_d;
  logic [PORTS-1:0]            in_range;
  logic [PORTS-1:0][WIDTH-1:0] wr_mask;
  logic [PORTS-1:0][WIDTH-1:0] rd_word;
  logic [PORTS-1:0]            rd_vld;
  logic [PORTS-1:0][WIDTH-1:0] dout;
  logic [PORTS-1:0]            dvld;
  logic                        coll_d, coll_q;
  logic [COLL_CNT_W-1:0]       coll_cnt_q;

  if (LENGTH < (1 << AW)) begin : g_rng
    for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign in_range[p] = (int'(bus.addr_i[p]) < LENGTH);
    end
  end else begin : g_full
    assign in_range = '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        if (clr_ptr_q == AW'(LENGTH - 1)) state_d = READY;
        else clr_ptr_d = clr_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Request decode: effective write bits and same-edge read word per port.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      wr_mask[p] = (state_q == READY && bus.en_i[p] && in_range[p]) ? bus.wrMask_i[p] : '0;
      rd_word[p] = in_range[p] ? mem[bus.addr_i[p]] : '0;
      if (WRITE_FIRST != 0)
        rd_word[p] = (rd_word[p] & ~wr_mask[p]) | (bus.dataIn_i[p] & wr_mask[p]);
      rd_vld[p]  = (state_q == READY) && bus.en_i[p];
    end
  end

  // Later ports are assigned last, so they win overlapping bits.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= INIT_VALUE;
    end else begin
      for (int p = 0; p < PORTS; p++)
        for (int i = 0; i < WIDTH; i++)
          if (wr_mask[p][i]) mem[bus.addr_i[p]][i] <= bus.dataIn_i[p][i];
    end
  end

  always_comb begin
    coll_d = 1'b0;
    for (int p = 0; p < PORTS; p++)
      for (int q = p + 1; q < PORTS; q++)
        if (bus.addr_i[p] == bus.addr_i[q] && |(wr_mask[p] & wr_mask[q])) coll_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll_d;
      if (coll_d && coll_cnt_q != '1) coll_cnt_q <= coll_cnt_q + 1'b1;
    end
  end

  // Read return pipeline, one per port.
  for (genvar p = 0; p < PORTS; p++) begin : g_dl
    sim_mem_delay_line #(.WIDTH(WIDTH), .DELAY(DELAY)) u_dl (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .vld_i  (rd_vld[p]),
      .data_i (rd_word[p]),
      .vld_o  (dvld[p]),
      .data_o (dout[p])
    );
  end

  assign bus.ready_o        = (state_q == READY);
  assign bus.dataOut_o      = dout;
  assign bus.valid_o        = dvld;
  assign bus.collision_o    = coll_q;
  assign bus.collisionCnt_o = coll_cnt_q;

endmodule
